// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: common data bus arbitration bundle.
//   Producer side : req_valid_in, req_rob_ix_in, req_value_in, req_dest_in,
//                   rob_head_in (ROB head, only meaningful in age mode)
//   Arbiter side  : req_ready_out (one-hot combinational grant),
//                   cdb_valid_out / cdb_rob_ix_out / cdb_value_out /
//                   cdb_dest_out / cdb_src_out (registered CDB beat)
// Modports: slave = arbiter, master = producers / ROB context.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned PTR_SIZE = 3
);
  localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]               req_valid_in;
  logic [NUM_REQ-1:0][PTR_SIZE-1:0] req_rob_ix_in;
  logic [NUM_REQ-1:0][31:0]         req_value_in;
  logic [NUM_REQ-1:0][31:0]         req_dest_in;
  logic [PTR_SIZE-1:0]              rob_head_in;

  logic [NUM_REQ-1:0]               req_ready_out;
  logic                             cdb_valid_out;
  logic [PTR_SIZE-1:0]              cdb_rob_ix_out;
  logic [31:0]                      cdb_value_out;
  logic [31:0]                      cdb_dest_out;
  logic [SRC_W-1:0]                 cdb_src_out;

  modport slave (
    input  req_valid_in, req_rob_ix_in, req_value_in, req_dest_in, rob_head_in,
    output req_ready_out, cdb_valid_out, cdb_rob_ix_out, cdb_value_out,
           cdb_dest_out, cdb_src_out
  );

  modport master (
    output req_valid_in, req_rob_ix_in, req_value_in, req_dest_in, rob_head_in,
    input  req_ready_out, cdb_valid_out, cdb_rob_ix_out, cdb_value_out,
           cdb_dest_out, cdb_src_out
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants the single common data bus to at most one of NUM_REQ
// completing producers per cycle and drives one registered CDB beat that
// feeds the ROB write-back port and the reservation-station snoop ports.
// Ports:
//   clk_in  - clock, all state on posedge
//   rst_in  - synchronous active-high reset
//   bus     - cdb_arbiter_if.slave (request payloads in, one-hot grant and
//             registered CDB beat out)
// Arbitration: round-robin starting at rr_ptr; rr_ptr moves to winner+1.
// Optional feature macro: CDB_AGE_PRIO_EN -- when defined, the requester whose
// ROB index is closest to rob_head_in (oldest) wins, ties in round-robin order.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned PTR_SIZE = 3
) (
  input  logic         clk_in,
  input  logic         rst_in,
  cdb_arbiter_if.slave bus
);
  localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned IW    = SRC_W + 1;

  logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                grant_any;
  logic [SRC_W-1:0]    winner;
  logic [NUM_REQ-1:0]  ready;
  logic [IW-1:0]       sum;
  logic [SRC_W-1:0]    idx;

  logic                cdb_valid_q;
  logic [PTR_SIZE-1:0] cdb_rob_ix_q;
  logic [31:0]         cdb_value_q;
  logic [31:0]         cdb_dest_q;
  logic [SRC_W-1:0]    cdb_src_q;

`ifdef CDB_AGE_PRIO_EN
  logic [PTR_SIZE-1:0] age;
  logic [PTR_SIZE-1:0] best_age;
`else
  logic unused_rob_head;
  assign unused_rob_head = &{1'b0, bus.rob_head_in};
`endif

  // Candidates are visited in round-robin order; in age mode a later
  // candidate only displaces the current one with a strictly smaller age,
  // so equal ages resolve in round-robin order.
  always_comb begin
    grant_any = 1'b0;
    winner    = '0;
    sum       = '0;
    idx       = '0;
`ifdef CDB_AGE_PRIO_EN
    age       = '0;
    best_age  = '1;
`endif
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, rr_ptr_q} + IW'(off);
      if (sum >= IW'(NUM_REQ)) sum = sum - IW'(NUM_REQ);
      idx = sum[SRC_W-1:0];
`ifdef CDB_AGE_PRIO_EN
      age = bus.req_rob_ix_in[idx] - bus.rob_head_in;
      if (bus.req_valid_in[idx] && (!grant_any || (age < best_age))) begin
        grant_any = 1'b1;
        winner    = idx;
        best_age  = age;
      end
`else
      if (bus.req_valid_in[idx] && !grant_any) begin
        grant_any = 1'b1;
        winner    = idx;
      end
`endif
    end
  end

  always_comb begin
    ready    = '0;
    rr_ptr_d = rr_ptr_q;
    if (grant_any && !rst_in) begin
      ready[winner] = 1'b1;
      rr_ptr_d = (winner == SRC_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr_q     <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_rob_ix_q <= '0;
      cdb_value_q  <= '0;
      cdb_dest_q   <= '0;
      cdb_src_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= grant_any;
      if (grant_any) begin
        cdb_rob_ix_q <= bus.req_rob_ix_in[winner];
        cdb_value_q  <= bus.req_value_in[winner];
        cdb_dest_q   <= bus.req_dest_in[winner];
        cdb_src_q    <= winner;
      end
    end
  end

  assign bus.req_ready_out  = ready;
  assign bus.cdb_valid_out  = cdb_valid_q;
  assign bus.cdb_rob_ix_out = cdb_rob_ix_q;
  assign bus.cdb_value_out  = cdb_value_q;
  assign bus.cdb_dest_out   = cdb_dest_q;
  assign bus.cdb_src_out    = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: reset check, a table of grant vectors, hand
// sequences for single requester / wrap-skip / age order, then randomized
// protocol-legal traffic compared against a behavioural arbitration model.
module tb_cdb_arbiter;
  logic clk;
  logic rst;

  cdb_arbiter_if #(.NUM_REQ(4), .PTR_SIZE(3)) bus ();

  cdb_arbiter #(.NUM_REQ(4), .PTR_SIZE(3)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // stimulus shadow (bench-owned)
  logic [3:0]  v_valid;
  logic [2:0]  v_ix   [4];
  logic [31:0] v_val  [4];
  logic [31:0] v_dest [4];
  logic [2:0]  v_head;

  // reference model state
  int          rr;
  bit          m_valid;
  logic [2:0]  m_ix;
  logic [31:0] m_val;
  logic [31:0] m_dest;
  int          m_src;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] ready;
  } row_t;
  row_t tab[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    bus.req_valid_in = v_valid;
    for (int i = 0; i < 4; i++) begin
      bus.req_rob_ix_in[i] = v_ix[i];
      bus.req_value_in[i]  = v_val[i];
      bus.req_dest_in[i]   = v_dest[i];
    end
    bus.rob_head_in = v_head;
  endtask

  // Winner: scan producers starting at rr, wrapping; in age mode the
  // smallest (ix - head) mod 8 wins, earlier in scan order on ties.
  function automatic int model_winner();
    int best = -1;
    int best_age = 1000;
    for (int k = 0; k < 4; k++) begin
      int i = (rr + k) % 4;
      int a = 0;
`ifdef CDB_AGE_PRIO_EN
      a = (int'(v_ix[i]) - int'(v_head) + 8) % 8;
`endif
      if (v_valid[i] && a < best_age) begin
        best = i;
        best_age = a;
      end
    end
    return best;
  endfunction

  // One cycle: inputs already driven after a posedge; check at negedge.
  task automatic step(input bit use_tab, input logic [3:0] tab_ready, output int w);
    logic [3:0] exp_ready;
    @(negedge clk);
    w = model_winner();
    exp_ready = (w < 0) ? 4'b0000 : 4'(1 << w);
    check("ready", 64'(bus.req_ready_out), 64'(exp_ready));
    if (use_tab) check("tab_ready", 64'(bus.req_ready_out), 64'(tab_ready));
    check("cdb_valid", 64'(bus.cdb_valid_out), 64'(m_valid));
    if (m_valid) begin
      check("cdb_ix",    64'(bus.cdb_rob_ix_out), 64'(m_ix));
      check("cdb_value", 64'(bus.cdb_value_out),  64'(m_val));
      check("cdb_dest",  64'(bus.cdb_dest_out),   64'(m_dest));
      check("cdb_src",   64'(bus.cdb_src_out),    64'(m_src));
    end
    m_valid = (w >= 0);
    if (w >= 0) begin
      m_ix   = v_ix[w];
      m_val  = v_val[w];
      m_dest = v_dest[w];
      m_src  = w;
      rr     = (w + 1) % 4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    v_valid = 4'b1111;
    drive();
    @(negedge clk);
    check("rst_ready", 64'(bus.req_ready_out), 64'(0));
    @(posedge clk);
    #1;
    check("rst_cdb_valid", 64'(bus.cdb_valid_out),  64'(0));
    check("rst_cdb_ix",    64'(bus.cdb_rob_ix_out), 64'(0));
    check("rst_cdb_value", 64'(bus.cdb_value_out),  64'(0));
    check("rst_cdb_dest",  64'(bus.cdb_dest_out),   64'(0));
    check("rst_cdb_src",   64'(bus.cdb_src_out),    64'(0));
    rst = 1'b0;
    v_valid = 4'b0000;
    drive();
    rr = 0;
    m_valid = 1'b0;
  endtask

  initial begin
    int w;
    rst = 1'b1;
    v_valid = '0;
    v_head = '0;
    for (int i = 0; i < 4; i++) begin
      v_ix[i] = '0;
      v_val[i] = 32'd100 + 32'(i);
      v_dest[i] = 32'h200 + 32'(i);
    end
    drive();

    // grant sequence from reset (rr pointer starts at 0)
    tab[0]  = '{4'b1111, 4'b0001};
    tab[1]  = '{4'b1111, 4'b0010};
    tab[2]  = '{4'b1111, 4'b0100};
    tab[3]  = '{4'b1111, 4'b1000};
    tab[4]  = '{4'b1111, 4'b0001};
    tab[5]  = '{4'b1111, 4'b0010};
    tab[6]  = '{4'b0000, 4'b0000};
    tab[7]  = '{4'b0011, 4'b0001};
    tab[8]  = '{4'b1010, 4'b0010};
    tab[9]  = '{4'b1010, 4'b1000};
    tab[10] = '{4'b0110, 4'b0010};
    tab[11] = '{4'b0100, 4'b0100};
    tab[12] = '{4'b0001, 4'b0001};

    do_reset();
    for (int r = 0; r < 13; r++) begin
      v_valid = tab[r].valid;
      drive();
      step(1'b1, tab[r].ready, w);
    end
    v_valid = '0;
    drive();
    step(1'b1, 4'b0000, w);

    // single requester held three cycles
    do_reset();
    v_valid = 4'b0100;
    v_ix[2] = 3'd5;
    v_val[2] = -32'sd7;
    v_dest[2] = 32'h10;
    drive();
    for (int c = 0; c < 3; c++) step(1'b1, 4'b0100, w);
    v_valid = '0;
    drive();
    step(1'b1, 4'b0000, w);
    check("single_value", 64'(bus.cdb_value_out), 64'(32'hFFFF_FFF9));
    step(1'b1, 4'b0000, w);

    // wrap / skip with rr pointer at 3
    do_reset();
    for (int i = 0; i < 4; i++) v_ix[i] = '0;
    v_valid = 4'b0001; drive(); step(1'b1, 4'b0001, w);
    v_valid = 4'b0010; drive(); step(1'b1, 4'b0010, w);
    v_valid = 4'b0100; drive(); step(1'b1, 4'b0100, w);
    v_valid = 4'b1010; drive(); step(1'b1, 4'b1000, w);
    v_valid = 4'b1010; drive(); step(1'b1, 4'b0010, w);
    v_valid = 4'b1010; drive(); step(1'b1, 4'b1000, w);
    v_valid = '0; drive(); step(1'b1, 4'b0000, w);

`ifdef CDB_AGE_PRIO_EN
    do_reset();
    v_head = 3'd6;
    v_ix[0] = 3'd1; v_ix[1] = 3'd7; v_ix[2] = 3'd6;
    v_valid = 4'b0111; drive(); step(1'b1, 4'b0100, w);
    v_valid = 4'b0011; drive(); step(1'b1, 4'b0010, w);
    v_valid = 4'b0001; drive(); step(1'b1, 4'b0001, w);
    v_valid = '0; drive(); step(1'b1, 4'b0000, w);
`endif

    // randomized protocol-legal traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!v_valid[i] && ($urandom_range(0, 1) == 1)) begin
          v_valid[i] = 1'b1;
          v_ix[i]   = 3'($urandom_range(0, 7));
          v_val[i]  = $urandom;
          v_dest[i] = $urandom;
        end
      end
      v_head = 3'($urandom_range(0, 7));
      drive();
      step(1'b0, 4'b0000, w);
      if (w >= 0) v_valid[w] = 1'b0;
    end
    v_valid = '0;
    drive();
    step(1'b0, 4'b0000, w);
    step(1'b0, 4'b0000, w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
